// File: rtl/muldiv_seq_unit.sv
// muldiv_seq_unit: iterative RISC-V M-extension multiply/divide unit with valid/ready handshake
// Ports: clk, rst (sync, active-high), flush; request side in_valid/in_ready, op, operand_a, operand_b;
// response side out_valid/out_ready, result, zero, overflow; busy while not idle.
// Optional MULDIV_FAST_MUL_EN: MUL* ops use a single-cycle multiplier instead of the shift-add loop.
module muldiv_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t             state_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_abs_q, b_abs_q, result_q;
  logic               neg_q, out_valid_q, zero_q, ovf_q;
  logic [2*WIDTH-1:0] acc_q, acc_d, shl;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH:0]     trial;
  logic               sa, sb, neg_d, div_zero, div_ovf, fast_go;
  logic [WIDTH-1:0]   a_abs_d, b_abs_d, spec_res, calc_res, fast_res, res_now;
  function automatic logic [WIDTH-1:0] finish_res(input logic [2*WIDTH-1:0] acc, input logic neg,
                                                  input logic [2:0] o);
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   q, r;
    p = neg ? -acc : acc;
    q = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r = neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    return o[2] ? (o[1] ? r : q) : (o[1:0] == 2'b00 ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH]);
  endfunction
  // Operand signedness: divides are signed unless op[0]; MULHSU has only rs1 signed, MULHU neither.
  always_comb begin
    sa       = operand_a[WIDTH-1] & (op[2] ? !op[0] : op != 3'b011);
    sb       = operand_b[WIDTH-1] & (op[2] ? !op[0] : !op[1]);
    a_abs_d  = sa ? -operand_a : operand_a;
    b_abs_d  = sb ? -operand_b : operand_b;
    neg_d    = (op[2] && op[1]) ? sa : sa ^ sb;
    div_zero = op[2] && operand_b == '0;
    div_ovf  = op[2] && !op[0] && operand_a == INT_MIN && operand_b == '1;
    spec_res = div_zero ? (op[1] ? operand_a : '1) : (op[1] ? '0 : operand_a);
  end
  // acc holds the product for multiplies and {remainder, dividend/quotient} for divides.
  // The trial subtract keeps the bit shifted out of the remainder so large divisors stay exact.
  always_comb begin
    idx   = IDX_W'(WIDTH-1) - cnt_q[IDX_W-1:0];
    shl   = acc_q << 1;
    trial = {acc_q[2*WIDTH-1], shl[2*WIDTH-1:WIDTH]} - {1'b0, b_abs_q};
    acc_d = op_q[2] ? (trial[WIDTH] ? shl : {trial[WIDTH-1:0], shl[WIDTH-1:1], 1'b1})
                    : acc_q + (b_abs_q[idx] ? ({{WIDTH{1'b0}}, a_abs_q} << idx) : '0);
  end
  assign calc_res = finish_res(acc_d, neg_q, op_q);
`ifdef MULDIV_FAST_MUL_EN
  assign fast_go  = !op[2];
  assign fast_res = finish_res({{WIDTH{1'b0}}, a_abs_d} * {{WIDTH{1'b0}}, b_abs_d}, neg_d, op);
`else
  assign fast_go  = 1'b0;
  assign fast_res = '0;
`endif
  assign res_now = fast_go ? fast_res : spec_res;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_abs_q     <= '0;
      b_abs_q     <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid && in_ready) begin
          op_q    <= op;
          a_abs_q <= a_abs_d;
          b_abs_q <= b_abs_d;
          neg_q   <= neg_d;
          acc_q   <= op[2] ? {{WIDTH{1'b0}}, a_abs_d} : '0;
          cnt_q   <= CNT_W'(WIDTH-1);
          if (div_zero || div_ovf || fast_go) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= res_now;
            zero_q      <= res_now == '0;
            ovf_q       <= div_zero || (div_ovf && !op[1]);
          end else begin
            state_q <= CALC;
          end
        end
        CALC: if (flush) begin
          state_q <= IDLE;
        end else begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= calc_res;
            zero_q      <= calc_res == '0;
            ovf_q       <= 1'b0;
          end
        end
        DONE: if (flush || out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          zero_q      <= 1'b0;
          ovf_q       <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = state_q == IDLE && !flush && !rst;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_muldiv_seq_unit.sv
// tb_muldiv_seq_unit: scoreboard bench for muldiv_seq_unit against an arithmetic reference model
module tb_muldiv_seq_unit;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         ov;
    int           lat;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0] op = '0;
  logic [W-1:0] operand_a = '0, operand_b = '0;
  logic in_ready, out_valid, zero, overflow, busy;
  logic [W-1:0] result;
  exp_t sb_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, acc_cyc = 0;
  logic ov_prev = 1'b0;
  muldiv_seq_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .overflow(overflow), .busy(busy)
  );
  always #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int sa, sb;
    longint pa, pb;
    logic [63:0] p;
    logic [W-1:0] r;
    bit ov, spec, min_neg1;
    sa = a;
    sb = b;
    ov = 0;
    spec = 0;
    r = '0;
    min_neg1 = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin pa = sa; pb = sb; p = pa * pb; r = p[31:0]; end
      3'd1: begin pa = sa; pb = sb; p = pa * pb; r = p[63:32]; end
      3'd2: begin pa = sa; pb = {32'b0, b}; p = pa * pb; r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: if (b == 0) begin r = '1; ov = 1; spec = 1; end
            else if (min_neg1) begin r = a; ov = 1; spec = 1; end
            else r = sa / sb;
      3'd5: if (b == 0) begin r = '1; ov = 1; spec = 1; end else r = a / b;
      3'd6: if (b == 0) begin r = a; ov = 1; spec = 1; end
            else if (min_neg1) begin r = '0; spec = 1; end
            else r = sa % sb;
      default: if (b == 0) begin r = a; ov = 1; spec = 1; end else r = a % b;
    endcase
    e.res = r;
    e.z = (r == 0);
    e.ov = ov;
    e.lat = spec ? 1 : (o[2] ? W + 1 : MUL_LAT);
    return e;
  endfunction
  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction
  initial forever begin
    @(negedge clk);
    if (in_valid && in_ready) acc_cyc = cyc;
    if (out_valid && !ov_prev) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_out_valid: got result %0h expected no response", result);
      end else chk("latency", 64'(cyc - acc_cyc), 64'(sb_q[0].lat));
    end
    if (out_valid && out_ready && !flush && sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("result", result, e.res);
      chk("zero", zero, e.z);
      chk("overflow", overflow, e.ov);
    end
    ov_prev = out_valid;
  end
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input exp_t e);
    bit ok;
    @(posedge clk);
    #1;
    op = o;
    operand_a = a;
    operand_b = b;
    in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready 0 expected 1");
    end else if (push) sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 3'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
  endtask
  task automatic finish_op(input bit rnd_rdy);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL response_timeout: out_valid 0 expected 1");
    end
    chk("in_ready_during_handshake", in_ready, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_after_handshake", in_ready, 1);
    chk("out_valid_after_handshake", out_valid, 0);
    chk("zero_after_handshake", zero, 0);
    chk("overflow_after_handshake", overflow, 0);
  endtask
  task automatic dir(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] r, input logic z, input logic ov, input int lat);
    exp_t e;
    e.res = r;
    e.z = z;
    e.ov = ov;
    e.lat = lat;
    issue(o, a, b, 1, e);
    finish_op(1);
  endtask
  initial begin
    exp_t none;
    none = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    dir(3'd5, 100, 7, 14, 0, 0, W + 1);
    dir(3'd7, 100, 7, 2, 0, 0, W + 1);
    dir(3'd4, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 0, 0, W + 1);
    dir(3'd6, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 0, 0, W + 1);
    dir(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1, 1);
    dir(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 0, 1);
    dir(3'd5, 5, 0, 32'hFFFF_FFFF, 0, 1, 1);
    dir(3'd7, 5, 0, 5, 0, 1, 1);
    dir(3'd4, 7, 0, 32'hFFFF_FFFF, 0, 1, 1);
    dir(3'd6, 0, 0, 0, 1, 1, 1);
    dir(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 0, MUL_LAT);
    dir(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, MUL_LAT);
    dir(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, MUL_LAT);
    dir(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, MUL_LAT);
    dir(3'd0, 32'h0001_0000, 32'h0001_0000, 0, 1, 0, MUL_LAT);
    dir(3'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 1, 0, W + 1);
    issue(3'd5, 100, 7, 1, model(3'd5, 100, 7));
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_valid", out_valid, 1);
      chk("stall_result", result, 14);
      chk("stall_zero", zero, 0);
      chk("stall_in_ready", in_ready, 0);
      @(negedge clk);
    end
    finish_op(0);
    issue(3'd5, 1000, 3, 0, none);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_out_valid", out_valid, 0);
    repeat (40) @(negedge clk);
    chk("flush_in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b1;
    op = 3'd5;
    operand_a = 50;
    operand_b = 5;
    repeat (3) begin
      @(negedge clk);
      chk("idle_flush_in_ready", in_ready, 0);
      chk("idle_flush_busy", busy, 0);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_flush_no_accept", busy, 0);
    issue(3'd4, $urandom, 32'd12345, 0, none);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_result", result, 0);
    chk("rst_mid_zero", zero, 0);
    chk("rst_mid_overflow", overflow, 0);
    chk("rst_mid_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_ready_after", in_ready, 1);
    dir(3'd5, 9, 3, 3, 0, 0, W + 1);
    for (int i = 0; i < 80; i++) begin
      logic [2:0] o;
      logic [W-1:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      issue(o, a, b, 1, model(o, a, b));
      finish_op(1);
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
